// File: rtl/uart_tx_arbiter_pkg.sv
// rtl/uart_tx_arbiter_pkg.sv - shared states, default parameters and width helpers for uart_tx_arbiter
package uart_tx_arbiter_pkg;

`ifdef UART_TX_ARBITER_GAP_EN
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND      = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_GAP       = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND      = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_t;
`endif

    localparam int C_NB_REQ       = 2;
    localparam int C_DATA_WIDTH   = 8;
    localparam int C_MAX_BURST    = 16;
    localparam int C_IDLE_TIMEOUT = 64;
    localparam int C_GAP_CYCLES   = 10;

    // Bits needed to hold a counter value 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int C_PTR_W       = idx_width(C_NB_REQ);
    localparam int C_BURST_CNT_W = cnt_width(C_MAX_BURST);
    localparam int C_IDLE_CNT_W  = cnt_width(C_IDLE_TIMEOUT);
    localparam int C_GAP_CNT_W   = cnt_width(C_GAP_CYCLES);

endpackage

// File: rtl/rr_priority_encoder.sv
// rtl/rr_priority_encoder.sv - one-hot pick of the first set request at or after a rotating pointer
module rr_priority_encoder
    import uart_tx_arbiter_pkg::*;
#(
    parameter int G_NB_REQ = C_NB_REQ,
    parameter int PTR_W    = idx_width(G_NB_REQ)
) (
    input  logic [G_NB_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]    ptr_i,
    output logic [G_NB_REQ-1:0] grant_o,
    output logic                valid_o
);

    always_comb begin
        int idx;
        idx     = 0;
        grant_o = '0;
        valid_o = 1'b0;
        for (int i = 0; i < G_NB_REQ; i++) begin
            idx = int'(ptr_i) + i;
            if (idx >= G_NB_REQ) begin
                idx = idx - G_NB_REQ;
            end
            if (!valid_o && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                valid_o      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of one UART transmitter; UART_TX_ARBITER_GAP_EN adds an inter-frame gap
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int G_NB_REQ       = C_NB_REQ,
    parameter int G_DATA_WIDTH   = C_DATA_WIDTH,
    parameter int G_MAX_BURST    = C_MAX_BURST,
    parameter int G_IDLE_TIMEOUT = C_IDLE_TIMEOUT,
    parameter int G_GAP_CYCLES   = C_GAP_CYCLES
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [G_NB_REQ-1:0]              i_req_valid,
    input  logic [G_NB_REQ*G_DATA_WIDTH-1:0] i_req_data,
    input  logic [G_NB_REQ-1:0]              i_req_last,
    output logic [G_NB_REQ-1:0]              o_req_ready,
    output logic [G_NB_REQ-1:0]              o_grant,
    output logic                             o_tx_start,
    output logic [G_DATA_WIDTH-1:0]          o_tx_data,
    input  logic                             i_tx_done,
    output logic                             o_busy
);

    localparam int PTR_W   = idx_width(G_NB_REQ);
    localparam int BURST_W = cnt_width(G_MAX_BURST);
    localparam int IDLE_W  = cnt_width(G_IDLE_TIMEOUT);

    generate
        if (G_NB_REQ < 1 || G_NB_REQ > 8 || G_MAX_BURST < 1 || G_MAX_BURST > 255 ||
            G_IDLE_TIMEOUT < 1 || G_IDLE_TIMEOUT > 1023 || G_GAP_CYCLES < 1 ||
            G_DATA_WIDTH < 1) begin : g_param_check
            $error("uart_tx_arbiter: parameter out of range");
        end
    endgenerate

    state_t                  state_q, state_d;
    logic [G_NB_REQ-1:0]     grant_q, grant_d;
    logic [PTR_W-1:0]        gidx_q, gidx_d;
    logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [BURST_W-1:0]      burst_q, burst_d;
    logic [IDLE_W-1:0]       idle_q, idle_d;
    logic [IDLE_W-1:0]       idle_inc;
    logic [G_DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                    last_q, last_d;
    logic                    tx_start_q, tx_start_d;
    logic                    release_grant;

    logic [G_NB_REQ-1:0]     enc_grant;
    logic                    enc_valid;
    logic [PTR_W-1:0]        enc_idx;

`ifdef UART_TX_ARBITER_GAP_EN
    localparam int GAP_W = cnt_width(G_GAP_CYCLES);
    logic [GAP_W-1:0]        gap_q, gap_d;
`endif

    rr_priority_encoder #(
        .G_NB_REQ (G_NB_REQ),
        .PTR_W    (PTR_W)
    ) u_rr_enc (
        .req_i   (i_req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (enc_grant),
        .valid_o (enc_valid)
    );

    always_comb begin
        enc_idx = '0;
        for (int i = 0; i < G_NB_REQ; i++) begin
            if (enc_grant[i]) begin
                enc_idx = PTR_W'(i);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        gidx_d        = gidx_q;
        rr_ptr_d      = rr_ptr_q;
        burst_d       = burst_q;
        idle_d        = idle_q;
        tx_data_d     = tx_data_q;
        last_d        = last_q;
        tx_start_d    = 1'b0;
        release_grant = 1'b0;
        idle_inc      = (idle_q == IDLE_W'(G_IDLE_TIMEOUT)) ? idle_q : idle_q + 1'b1;
`ifdef UART_TX_ARBITER_GAP_EN
        gap_d         = gap_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (enc_valid) begin
                    grant_d = enc_grant;
                    gidx_d  = enc_idx;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (i_req_valid[gidx_q]) begin
                    tx_data_d  = i_req_data[int'(gidx_q)*G_DATA_WIDTH +: G_DATA_WIDTH];
                    last_d     = i_req_last[gidx_q];
                    tx_start_d = 1'b1;
                    idle_d     = '0;
                    state_d    = ST_WAIT_DONE;
                end else if (idle_inc == IDLE_W'(G_IDLE_TIMEOUT)) begin
                    release_grant = 1'b1;
                end else begin
                    idle_d = idle_inc;
                end
            end
            ST_WAIT_DONE: begin
                if (i_tx_done) begin
                    if (last_q || (burst_q + 1'b1) == BURST_W'(G_MAX_BURST)) begin
                        release_grant = 1'b1;
                    end else begin
                        burst_d = burst_q + 1'b1;
                        state_d = ST_SEND;
                    end
                end
            end
`ifdef UART_TX_ARBITER_GAP_EN
            ST_GAP: begin
                if (gap_q == GAP_W'(G_GAP_CYCLES - 1)) begin
                    gap_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        // Next owner search starts just past the requester being released.
        if (release_grant) begin
            grant_d  = '0;
            burst_d  = '0;
            idle_d   = '0;
            rr_ptr_d = (int'(gidx_q) == G_NB_REQ - 1) ? '0 : gidx_q + 1'b1;
`ifdef UART_TX_ARBITER_GAP_EN
            gap_d    = '0;
            state_d  = ST_GAP;
`else
            state_d  = ST_IDLE;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            gidx_q     <= '0;
            rr_ptr_q   <= '0;
            burst_q    <= '0;
            idle_q     <= '0;
            tx_data_q  <= '0;
            last_q     <= 1'b0;
            tx_start_q <= 1'b0;
`ifdef UART_TX_ARBITER_GAP_EN
            gap_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            gidx_q     <= gidx_d;
            rr_ptr_q   <= rr_ptr_d;
            burst_q    <= burst_d;
            idle_q     <= idle_d;
            tx_data_q  <= tx_data_d;
            last_q     <= last_d;
            tx_start_q <= tx_start_d;
`ifdef UART_TX_ARBITER_GAP_EN
            gap_q      <= gap_d;
`endif
        end
    end

    assign o_req_ready = (state_q == ST_SEND) ? grant_q : '0;
    assign o_grant     = grant_q;
    assign o_tx_start  = tx_start_q;
    assign o_tx_data   = tx_data_q;
    assign o_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter (directed scenarios plus randomized frames)
module tb_uart_tx_arbiter;

    localparam int NB  = 2;
    localparam int W   = 8;
    localparam int MB  = 16;
    localparam int TO  = 64;
    localparam int GAP = 10;
`ifdef UART_TX_ARBITER_GAP_EN
    localparam int EXP_GAP_BUSY = GAP;
`else
    localparam int EXP_GAP_BUSY = 0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [NB-1:0]   i_req_valid;
    logic [NB*W-1:0] i_req_data;
    logic [NB-1:0]   i_req_last;
    logic [NB-1:0]   o_req_ready;
    logic [NB-1:0]   o_grant;
    logic            o_tx_start;
    logic [W-1:0]    o_tx_data;
    logic            i_tx_done;
    logic            o_busy;

    uart_tx_arbiter #(
        .G_NB_REQ       (NB),
        .G_DATA_WIDTH   (W),
        .G_MAX_BURST    (MB),
        .G_IDLE_TIMEOUT (TO),
        .G_GAP_CYCLES   (GAP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_req_valid (i_req_valid),
        .i_req_data  (i_req_data),
        .i_req_last  (i_req_last),
        .o_req_ready (o_req_ready),
        .o_grant     (o_grant),
        .o_tx_start  (o_tx_start),
        .o_tx_data   (o_tx_data),
        .i_tx_done   (i_tx_done),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc = 0, n_start = 0, uart_cnt = 0, uart_delay = 20;
    int done_cyc = 0, send0_cyc = 0, cur_run = 0, last_owner = 1;
    bit rand_delay = 0, sb_en = 0, run_last = 0;
    logic [8:0] rq0[$], rq1[$], exp0[$], exp1[$];
    logic [7:0] sent_data[$];
    int sent_own[$], runs[$], rel_cycs[$];
    logic [1:0] prev_grant = '0;
    logic prev_rdy0 = 1'b0;

    function automatic int owner_of(input logic [1:0] g);
        if (g == 2'b01) return 0;
        if (g == 2'b10) return 1;
        return -1;
    endfunction

    task automatic drive();
        i_req_valid[0]  = (rq0.size() > 0);
        i_req_data[7:0] = (rq0.size() > 0) ? rq0[0][7:0] : 8'h00;
        i_req_last[0]   = (rq0.size() > 0) ? rq0[0][8] : 1'b0;
        i_req_valid[1]  = (rq1.size() > 0);
        i_req_data[15:8]= (rq1.size() > 0) ? rq1[0][7:0] : 8'h00;
        i_req_last[1]   = (rq1.size() > 0) ? rq1[0][8] : 1'b0;
    endtask

    task automatic push(input int k, input logic [7:0] d, input logic l);
        if (k == 0) begin rq0.push_back({l, d}); exp0.push_back({l, d}); end
        else        begin rq1.push_back({l, d}); exp1.push_back({l, d}); end
        drive();
    endtask

    task automatic tick();
        logic [1:0] hs, pv;
        logic [8:0] expv;
        bit have;
        int own, exp_own;
        hs = i_req_valid & o_req_ready;
        pv = i_req_valid;
        @(posedge clk);
        #1;
        cyc++;
        if (hs[0]) void'(rq0.pop_front());
        if (hs[1]) void'(rq1.pop_front());
        i_tx_done = 1'b0;
        if (uart_cnt > 0) begin
            uart_cnt--;
            if (uart_cnt == 0) begin i_tx_done = 1'b1; done_cyc = cyc; end
        end
        own = owner_of(o_grant);
        if (o_tx_start) begin
            n_start++;
            cur_run++;
            sent_data.push_back(o_tx_data);
            sent_own.push_back(own);
            uart_cnt = rand_delay ? int'($urandom_range(1, 6)) : uart_delay;
            if (sb_en) begin
                have = 0;
                expv = '0;
                if (own == 0 && exp0.size() > 0) begin expv = exp0.pop_front(); have = 1; end
                else if (own == 1 && exp1.size() > 0) begin expv = exp1.pop_front(); have = 1; end
                run_last = expv[8];
                n_checks++;
                if (!have || o_tx_data !== expv[7:0])
                    $display("FAIL sb_data owner=%0d actual=%02h expected=%02h", own, o_tx_data, expv[7:0]);
                else n_pass++;
                n_checks++;
                if (cur_run > MB) $display("FAIL sb_burst run=%0d max=%0d", cur_run, MB);
                else n_pass++;
            end
        end
        if (o_grant != 0 && prev_grant == 0) begin
            if (sb_en) begin
                exp_own = (pv == 2'b11) ? 1 - last_owner : (pv[0] ? 0 : 1);
                n_checks++;
                if (own !== exp_own) $display("FAIL sb_rr actual=%0d expected=%0d", own, exp_own);
                else n_pass++;
            end
            last_owner = own;
        end
        if (o_grant == 0 && prev_grant != 0) begin
            if (sb_en) begin
                n_checks++;
                if (!(run_last || cur_run == MB))
                    $display("FAIL sb_release run=%0d last=%0b expected last or run=%0d", cur_run, run_last, MB);
                else n_pass++;
            end
            rel_cycs.push_back(cyc);
            runs.push_back(cur_run);
            cur_run = 0;
        end
        if (o_req_ready[0] && !prev_rdy0) send0_cyc = cyc;
        prev_grant = o_grant;
        prev_rdy0  = o_req_ready[0];
        drive();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rq0.delete(); rq1.delete(); exp0.delete(); exp1.delete();
        uart_cnt = 0;
        i_tx_done = 1'b0;
        drive();
        tick();
        tick();
        rst = 1'b0;
        sent_data.delete(); sent_own.delete(); runs.delete(); rel_cycs.delete();
        n_start = 0; cur_run = 0; last_owner = 1; run_last = 0;
    endtask

    task automatic wait_idle(input int n, input int bound, output bit ok);
        ok = 0;
        for (int i = 0; i < bound; i++) begin
            if (n_start >= n && o_grant == 0 && !o_busy && uart_cnt == 0) begin
                ok = 1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive();
        tick();
        tick();
        n_checks++; if (o_grant !== 2'b00) $display("FAIL rst_grant actual=%b expected=00", o_grant); else n_pass++;
        n_checks++; if (o_req_ready !== 2'b00) $display("FAIL rst_ready actual=%b expected=00", o_req_ready); else n_pass++;
        n_checks++; if (o_tx_start !== 1'b0) $display("FAIL rst_start actual=%b expected=0", o_tx_start); else n_pass++;
        n_checks++; if (o_tx_data !== 8'h00) $display("FAIL rst_data actual=%02h expected=00", o_tx_data); else n_pass++;
        n_checks++; if (o_busy !== 1'b0) $display("FAIL rst_busy actual=%b expected=0", o_busy); else n_pass++;
        push(0, 8'hC3, 1'b1);
        tick();
        tick();
        n_checks++; if (o_grant !== 2'b00) $display("FAIL rst_hold_grant actual=%b expected=00", o_grant); else n_pass++;
    endtask

    task automatic test_three_bytes();
        bit ok;
        do_reset();
        uart_delay = 20;
        push(0, 8'h11, 1'b0);
        push(0, 8'h22, 1'b0);
        push(0, 8'h33, 1'b1);
        wait_idle(3, 1000, ok);
        n_checks++; if (!ok) $display("FAIL three_timeout starts=%0d expected=3", n_start); else n_pass++;
        n_checks++; if (n_start !== 3) $display("FAIL three_count actual=%0d expected=3", n_start); else n_pass++;
        n_checks++;
        if (sent_data.size() != 3 || sent_data[0] !== 8'h11 || sent_data[1] !== 8'h22 || sent_data[2] !== 8'h33)
            $display("FAIL three_order actual=%p expected=11,22,33", sent_data);
        else n_pass++;
        n_checks++;
        if (rel_cycs.size() != 1 || rel_cycs[0] !== done_cyc + 1)
            $display("FAIL three_release actual=%p expected=%0d", rel_cycs, done_cyc + 1);
        else n_pass++;
        sent_own.delete();
        uart_delay = 3;
        push(0, 8'hA1, 1'b1);
        push(1, 8'hB1, 1'b1);
        wait_idle(5, 500, ok);
        n_checks++;
        if (!ok || sent_own.size() < 1 || sent_own[0] !== 1)
            $display("FAIL three_rrptr actual=%p expected first owner 1", sent_own);
        else n_pass++;
    endtask

    task automatic test_alternation();
        bit ok;
        do_reset();
        uart_delay = 3;
        push(0, 8'h01, 1'b1);
        push(0, 8'h03, 1'b1);
        push(1, 8'h02, 1'b1);
        push(1, 8'h04, 1'b1);
        wait_idle(4, 1000, ok);
        n_checks++; if (!ok) $display("FAIL alt_timeout starts=%0d expected=4", n_start); else n_pass++;
        n_checks++;
        if (sent_own.size() != 4 || sent_own[0] !== 0 || sent_own[1] !== 1 || sent_own[2] !== 0 || sent_own[3] !== 1)
            $display("FAIL alt_owner actual=%p expected=0,1,0,1", sent_own);
        else n_pass++;
        n_checks++;
        if (sent_data.size() != 4 || sent_data[0] !== 8'h01 || sent_data[1] !== 8'h02 || sent_data[2] !== 8'h03 || sent_data[3] !== 8'h04)
            $display("FAIL alt_data actual=%p expected=01,02,03,04", sent_data);
        else n_pass++;
    endtask

    task automatic test_burst_limit();
        bit ok;
        int bad;
        do_reset();
        uart_delay = 5;
        for (int i = 0; i < 20; i++) push(1, 8'(8'h40 + i), 1'b0);
        wait_idle(20, 3000, ok);
        n_checks++; if (!ok) $display("FAIL burst_timeout starts=%0d expected=20", n_start); else n_pass++;
        n_checks++;
        if (runs.size() != 2 || runs[0] !== MB || runs[1] !== 4)
            $display("FAIL burst_runs actual=%p expected=16,4", runs);
        else n_pass++;
        bad = 0;
        for (int i = 0; i < sent_data.size(); i++)
            if (sent_data[i] !== 8'(8'h40 + i) || sent_own[i] !== 1) bad++;
        n_checks++;
        if (bad != 0 || sent_data.size() != 20) $display("FAIL burst_data mismatches=%0d bytes=%0d expected 0 and 20", bad, sent_data.size());
        else n_pass++;
    endtask

    task automatic test_idle_timeout();
        bit ok;
        do_reset();
        uart_delay = 5;
        push(0, 8'h5A, 1'b0);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (n_start == 1) begin ok = 1; break; end
        end
        n_checks++; if (!ok) $display("FAIL idle_first_start actual=%0d expected=1", n_start); else n_pass++;
        push(1, 8'h6B, 1'b1);
        wait_idle(2, 1000, ok);
        n_checks++; if (!ok) $display("FAIL idle_timeout_wait starts=%0d expected=2", n_start); else n_pass++;
        n_checks++;
        if (rel_cycs.size() < 1 || rel_cycs[0] - send0_cyc !== TO)
            $display("FAIL idle_release_cycles actual=%0d expected=%0d", (rel_cycs.size() > 0) ? rel_cycs[0] - send0_cyc : -1, TO);
        else n_pass++;
        n_checks++;
        if (sent_own.size() != 2 || sent_own[1] !== 1 || sent_data[1] !== 8'h6B)
            $display("FAIL idle_next_owner actual=%p data=%p expected owner 1 data 6b", sent_own, sent_data);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit ok, saw;
        do_reset();
        uart_delay = 20;
        push(0, 8'h77, 1'b1);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (n_start == 1) begin ok = 1; break; end
        end
        tick(); tick(); tick();
        n_checks++; if (!ok || !o_busy) $display("FAIL rmid_in_flight started=%0b busy=%b expected 1 and 1", ok, o_busy); else n_pass++;
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({o_grant, o_req_ready, o_tx_start, o_busy} !== 6'b0 || o_tx_data !== 8'h00)
            $display("FAIL rmid_async grant=%b ready=%b start=%b busy=%b data=%02h expected all 0", o_grant, o_req_ready, o_tx_start, o_busy, o_tx_data);
        else n_pass++;
        rq0.delete(); exp0.delete();
        drive();
        tick(); tick();
        rst = 1'b0;
        saw = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (i_tx_done) begin saw = 1; break; end
        end
        tick(); tick(); tick();
        n_checks++; if (!saw) $display("FAIL rmid_stray_done seen=0 expected=1"); else n_pass++;
        n_checks++;
        if (o_grant !== 2'b00 || o_busy !== 1'b0 || n_start !== 1)
            $display("FAIL rmid_ignore grant=%b busy=%b starts=%0d expected 00,0,1", o_grant, o_busy, n_start);
        else n_pass++;
        uart_delay = 4;
        push(1, 8'h99, 1'b1);
        wait_idle(2, 500, ok);
        n_checks++;
        if (!ok || sent_data.size() != 2 || sent_data[1] !== 8'h99 || sent_own[1] !== 1)
            $display("FAIL rmid_fresh data=%p owner=%p expected second 99 from 1", sent_data, sent_own);
        else n_pass++;
    endtask

    task automatic test_gap();
        bit ok;
        int phase, gap_busy, idle_c;
        do_reset();
        uart_delay = 4;
        push(0, 8'h0A, 1'b1);
        push(1, 8'h0B, 1'b1);
        phase = 0; gap_busy = 0; idle_c = 0;
        for (int i = 0; i < 500; i++) begin
            tick();
            if (phase == 0) begin
                if (i_tx_done) phase = 1;
            end else begin
                if (o_grant != 0) begin phase = 2; break; end
                else if (o_busy) gap_busy++;
                else idle_c++;
            end
        end
        n_checks++; if (phase != 2) $display("FAIL gap_regrant phase=%0d expected=2", phase); else n_pass++;
        n_checks++; if (gap_busy !== EXP_GAP_BUSY) $display("FAIL gap_busy_cycles actual=%0d expected=%0d", gap_busy, EXP_GAP_BUSY); else n_pass++;
        n_checks++; if (idle_c !== 1) $display("FAIL gap_idle_cycles actual=%0d expected=1", idle_c); else n_pass++;
        wait_idle(2, 500, ok);
        n_checks++;
        if (!ok || sent_own.size() != 2 || sent_own[0] !== 0 || sent_own[1] !== 1)
            $display("FAIL gap_owner actual=%p expected=0,1", sent_own);
        else n_pass++;
    endtask

    task automatic test_random();
        bit ok;
        int len;
        do_reset();
        rand_delay = 1;
        sb_en = 1;
        for (int k = 0; k < 2; k++) begin
            for (int f = 0; f < 5; f++) begin
                len = int'($urandom_range(1, 20));
                for (int b = 0; b < len; b++) push(k, 8'($urandom), (b == len - 1));
            end
        end
        ok = 0;
        for (int i = 0; i < 20000; i++) begin
            if (exp0.size() == 0 && exp1.size() == 0 && o_grant == 0 && !o_busy && uart_cnt == 0) begin
                ok = 1;
                break;
            end
            tick();
        end
        n_checks++;
        if (!ok) $display("FAIL rand_drain remaining=%0d/%0d expected 0/0", exp0.size(), exp1.size());
        else n_pass++;
        sb_en = 0;
        rand_delay = 0;
    endtask

    initial begin
        rst = 1'b1;
        i_tx_done = 1'b0;
        i_req_valid = '0;
        i_req_data = '0;
        i_req_last = '0;
        test_reset();
        test_three_bytes();
        test_alternation();
        test_burst_limit();
        test_idle_timeout();
        test_reset_mid();
        test_gap();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
